hazard_controller: RTL and testbench

Pipeline interlock and scheduling controller for the five-stage MIPS core. Sits beside the decode stage, keeps a scoreboard of in-flight register writes for the EX, MEM and WB stages, and generates the decode stall, fetch flush and operand-forwarding selects. It also sequences the multi-cycle multiply/divide unit and holds HI/LO consumers until the result is ready.

---
 rtl/hazard_controller.sv | 105 ++++++++++
 tb/tb_hazard_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Decode-side interlock: EX/MEM/WB write scoreboard, mult/div busy counter,
// stall/flush/forward-select generation. Optional forwarding via `FORWARDING_EN.
module hazard_controller #(
   parameter int unsigned MULDIV_LAT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic [4:0] id_dest,
   input  logic       id_reg_write_en,
   input  logic       id_is_load,
   input  logic       id_is_muldiv,
   input  logic       id_reads_hilo,
   input  logic       id_redirect,
   output logic       stall_out,
   output logic       flush_out,
   output logic       muldiv_busy_out,
   output logic [1:0] fwd_a_sel_out,
   output logic [1:0] fwd_b_sel_out
);

   localparam int unsigned CNT_W = 6;
   localparam int unsigned REG_W = 5;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             is_load;
   } sb_entry_t;

   sb_entry_t        ex_q, mem_q, wb_q;
   logic [CNT_W-1:0] cnt_q;

   logic       raw_stall, md_stall, stall_c;
   logic [1:0] fwd_a_c, fwd_b_c;

   function automatic logic hit(input logic use_f, input logic [REG_W-1:0] src,
                                input sb_entry_t e);
      return use_f & (src != REG_W'(0)) & e.valid & (e.dest == src);
   endfunction

`ifdef FORWARDING_EN
   // Youngest producer wins; a load still in EX is stalled, so it maps to 00.
   function automatic logic [1:0] pick(input logic use_f, input logic [REG_W-1:0] src,
                                       input sb_entry_t ex, input sb_entry_t mem,
                                       input sb_entry_t wb);
      if (hit(use_f, src, ex))       return ex.is_load ? 2'b00 : 2'b01;
      else if (hit(use_f, src, mem)) return 2'b10;
      else if (hit(use_f, src, wb))  return 2'b11;
      else                           return 2'b00;
   endfunction
`endif

   always_comb begin
      raw_stall = 1'b0;
      fwd_a_c   = 2'b00;
      fwd_b_c   = 2'b00;
`ifdef FORWARDING_EN
      raw_stall = (hit(id_uses_rs, id_rs, ex_q) | hit(id_uses_rt, id_rt, ex_q)) & ex_q.is_load;
      fwd_a_c   = pick(id_uses_rs, id_rs, ex_q, mem_q, wb_q);
      fwd_b_c   = pick(id_uses_rt, id_rt, ex_q, mem_q, wb_q);
`else
      raw_stall = hit(id_uses_rs, id_rs, ex_q)  | hit(id_uses_rt, id_rt, ex_q) |
                  hit(id_uses_rs, id_rs, mem_q) | hit(id_uses_rt, id_rt, mem_q);
`endif
      md_stall  = (id_reads_hilo | id_is_muldiv) & (cnt_q != CNT_W'(0));
      stall_c   = id_valid & (raw_stall | md_stall);
   end

   // Scoreboard shift and mult/div countdown; a stalled instruction becomes a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         if (id_valid & id_reg_write_en & (id_dest != REG_W'(0)) & ~stall_c)
            ex_q <= sb_entry_t'{valid: 1'b1, dest: id_dest, is_load: id_is_load};
         else
            ex_q <= '0;
         if (id_valid & id_is_muldiv & ~stall_c)
            cnt_q <= CNT_W'(MULDIV_LAT);
         else if (cnt_q != CNT_W'(0))
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign stall_out       = ~reset & stall_c;
   assign flush_out       = ~reset & id_valid & id_redirect & ~stall_c;
   assign muldiv_busy_out = ~reset & (cnt_q != CNT_W'(0));
   assign fwd_a_sel_out   = reset ? 2'b00 : fwd_a_c;
   assign fwd_b_sel_out   = reset ? 2'b00 : fwd_b_c;

   // Load flags past EX and the WB entry are only consumed in some builds.
   logic unused_sb;
   assign unused_sb = ^{mem_q.is_load, wb_q};

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; expectations follow the FORWARDING_EN setting.
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_uses_rs, id_uses_rt, id_reg_write_en, id_is_load;
   logic       id_is_muldiv, id_reads_hilo, id_redirect;
   logic       stall_out, flush_out, muldiv_busy_out;
   logic [1:0] fwd_a_sel_out, fwd_b_sel_out;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_controller #(.MULDIV_LAT(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .id_dest         (id_dest),
      .id_reg_write_en (id_reg_write_en),
      .id_is_load      (id_is_load),
      .id_is_muldiv    (id_is_muldiv),
      .id_reads_hilo   (id_reads_hilo),
      .id_redirect     (id_redirect),
      .stall_out       (stall_out),
      .flush_out       (flush_out),
      .muldiv_busy_out (muldiv_busy_out),
      .fwd_a_sel_out   (fwd_a_sel_out),
      .fwd_b_sel_out   (fwd_b_sel_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // v rs rt urs urt dest we ld md hilo redir
   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dest,
                        input logic we, input logic ld, input logic md,
                        input logic hilo, input logic redir);
      id_valid = v;  id_rs = rs;  id_rt = rt;  id_uses_rs = urs;  id_uses_rt = urt;
      id_dest = dest;  id_reg_write_en = we;  id_is_load = ld;  id_is_muldiv = md;
      id_reads_hilo = hilo;  id_redirect = redir;
      #1;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      nop();
      repeat (3) tick();
   endtask

   task automatic chk_sf(input string tag, input logic s, input logic f);
      chk({tag, "_stall"}, {1'b0, stall_out}, {1'b0, s});
      chk({tag, "_flush"}, {1'b0, flush_out}, {1'b0, f});
   endtask

   task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
      chk({tag, "_fwd_a"}, fwd_a_sel_out, a);
      chk({tag, "_fwd_b"}, fwd_b_sel_out, b);
   endtask

   initial begin
      reset = 1'b1;
      // Reset forces outputs low even with a redirecting mult in decode.
      drive(1, 3, 3, 1, 1, 3, 1, 0, 1, 1, 1);
      chk_sf("rst", 0, 0);
      chk("rst_busy", {1'b0, muldiv_busy_out}, 2'b00);
      chk_fwd("rst", 2'b00, 2'b00);
      tick(); tick();
      reset = 1'b0;
      drain();

      // add $3 ; sub $4,$3,$5
      drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
      chk_sf("add", 0, 0);
      tick();
      drive(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0);
`ifdef FORWARDING_EN
      chk_sf("raw_ex", 0, 0);
      chk_fwd("raw_ex", 2'b01, 2'b00);
      tick();
`else
      chk_sf("raw_c0", 1, 0);
      tick();
      chk_sf("raw_c1", 1, 0);
      tick();
      chk_sf("raw_rel", 0, 0);
      chk_fwd("raw_rel", 2'b00, 2'b00);
      tick();
`endif
      drain();

      // lw $2 ; add $6,$2,$2
      drive(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0);
      tick();
      drive(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 0);
      chk_sf("lu_c0", 1, 0);
      chk("lu_c0_no01", {1'b0, fwd_a_sel_out == 2'b01}, 2'b00);
      tick();
`ifdef FORWARDING_EN
      chk_sf("lu_rel", 0, 0);
      chk_fwd("lu_rel", 2'b10, 2'b10);
`else
      chk_sf("lu_c1", 1, 0);
      tick();
      chk_sf("lu_rel", 0, 0);
      chk_fwd("lu_rel", 2'b00, 2'b00);
`endif
      tick();
      drain();

      // Loads/writes to $0 never create hazards.
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      tick();
      drive(1, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0);
      chk_sf("r0", 0, 0);
      chk_fwd("r0", 2'b00, 2'b00);
      tick();
      drain();

      // Invalid decode slot never stalls or flushes.
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
      tick();
      drive(0, 7, 7, 1, 1, 0, 0, 0, 0, 0, 1);
      chk_sf("inval", 0, 0);
      tick();
      drain();

`ifdef FORWARDING_EN
      // Priority: MEM/EX, then WB/MEM.
      drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0);
      tick();
      drive(1, 12, 13, 1, 1, 0, 0, 0, 0, 0, 0);
      chk_fwd("prio0", 2'b10, 2'b01);
      tick();
      chk_fwd("prio1", 2'b11, 2'b10);
      tick();
      drain();
`endif

      // mult ; mflo -> 8 stall cycles then issue.
      drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
      chk_sf("mult", 0, 0);
      chk("mult_busy0", {1'b0, muldiv_busy_out}, 2'b00);
      tick();
      drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         chk("mflo_stall", {1'b0, stall_out}, 2'b01);
         chk("mflo_busy", {1'b0, muldiv_busy_out}, 2'b01);
         tick();
      end
      chk_sf("mflo_rel", 0, 0);
      chk("mflo_busy_rel", {1'b0, muldiv_busy_out}, 2'b00);
      tick();
      drain();

      // Back-to-back mult: second waits, then reloads.
      drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
      tick();
      drive(1, 3, 4, 1, 1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         chk("m2_stall", {1'b0, stall_out}, 2'b01);
         tick();
      end
      chk_sf("m2_rel", 0, 0);
      tick();
      chk("m2_reload", {1'b0, muldiv_busy_out}, 2'b01);
      nop();
      tick();
      drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
      tick();

      // Reset mid-divide with add $9 in flight.
      reset = 1'b1;
      drive(1, 9, 9, 1, 1, 0, 0, 0, 0, 1, 1);
      chk_sf("rst_md", 0, 0);
      chk("rst_md_busy", {1'b0, muldiv_busy_out}, 2'b00);
      chk_fwd("rst_md", 2'b00, 2'b00);
      tick();
      reset = 1'b0;
      #1;
      chk_sf("post_rst", 0, 1);
      chk("post_rst_busy", {1'b0, muldiv_busy_out}, 2'b00);
      chk_fwd("post_rst", 2'b00, 2'b00);
      tick();
      drain();

      // beq with redirect, dependent on load in EX.
      drive(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0);
      tick();
      drive(1, 10, 11, 1, 1, 0, 0, 0, 0, 0, 1);
      chk_sf("br_c0", 1, 0);
      tick();
`ifndef FORWARDING_EN
      chk_sf("br_c1", 1, 0);
      tick();
`endif
      chk_sf("br_rel", 0, 1);
      tick();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
